// File: rtl/iob_ptfloat_normalize_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : iob_ptfloat_normalize_pkg                               |
// | Brief    : Shared constants for the pt-float mantissa normalizer.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package iob_ptfloat_normalize_pkg;

  // Controller states: accept, iterate the shift loop, hold the result
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : iob_ptfloat_normalize_pkg
`default_nettype wire

// File: rtl/iob_ptfloat_normalize.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : iob_ptfloat_normalize                                   |
// | Brief    : Sequential two's-complement mantissa normalizer. Shifts |
// |            the mantissa until its top two fraction bits differ,    |
// |            tracking the exponent, one decision per cycle.          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module iob_ptfloat_normalize
  import iob_ptfloat_normalize_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int EW_W      = 4,
  localparam int EW_MAX    = 2**EW_W - 1,
  localparam int EXP_MAX_W = EW_MAX,
  localparam int MAN_MAX_W = DATA_W - EW_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [EXP_MAX_W+1:0] exp_i,
  input  logic [MAN_MAX_W+1:0] man_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [EXP_MAX_W+1:0] exp_o,
  output logic [MAN_MAX_W-1:0] man_o,
  output logic                 man_sign_o,
  output logic                 zero_o
);

  localparam int EXP_W = EXP_MAX_W + 2;
  localparam int MAN_W = MAN_MAX_W + 2;
  // Most negative representable exponent: below this no further left shift
  localparam logic [EXP_W-1:0] EXP_FLOOR = {1'b1, {(EXP_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] STEP_DEC  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] STEP_INC1 = EXP_W'(1);
  localparam logic [EXP_W-1:0] STEP_INC2 = EXP_W'(2);

  logic [1:0]           state_q, state_d;
  logic [EXP_W-1:0]     e_q, e_d;
  logic [MAN_W-1:0]     m_q, m_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [MAN_MAX_W-1:0] man_q, man_d;
  logic                 zero_q, zero_d;

  logic                 w_zero;
  logic                 w_ovf2;
  logic                 w_ovf1;
  logic                 w_is_norm;
  logic                 w_at_floor;
  logic [EXP_W-1:0]     w_e_step;
  logic [EXP_W-1:0]     w_e_sum;

  assign w_zero     = ~|m_q;
  assign w_ovf2     = m_q[MAN_W-1] ^ m_q[MAN_W-2];
  assign w_ovf1     = m_q[MAN_W-2] ^ m_q[MAN_W-3];
  assign w_is_norm  = m_q[MAN_MAX_W-1] ^ m_q[MAN_MAX_W-2];
  assign w_at_floor = (e_q == EXP_FLOOR);

  // Single exponent adder shared by right-shift (+2/+1) and left-shift (-1)
  always_comb begin
    w_e_step = STEP_DEC;
    if (w_ovf2) begin
      w_e_step = STEP_INC2;
    end else if (w_ovf1) begin
      w_e_step = STEP_INC1;
    end
    w_e_sum = e_q + w_e_step;
  end

  // Next-state and datapath decisions, priority ordered inside NORM
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    m_d     = m_q;
    exp_d   = exp_q;
    man_d   = man_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          e_d     = exp_i;
          m_d     = man_i;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (w_zero) begin
          man_d   = '0;
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else if (w_ovf2) begin
          man_d   = m_q[MAN_W-1:2];
          exp_d   = w_e_sum;
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else if (w_ovf1) begin
          man_d   = m_q[MAN_W-2:1];
          exp_d   = w_e_sum;
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else if (w_is_norm || w_at_floor) begin
          // Normalized, or exponent cannot go lower: emit as-is
          man_d   = m_q[MAN_MAX_W-1:0];
          exp_d   = e_q;
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          m_d = {m_q[MAN_W-2:0], 1'b0};
          e_d = w_e_sum;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      e_q     <= '0;
      m_q     <= '0;
      exp_q   <= '0;
      man_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      zero_q  <= zero_d;
    end
  end

  // ready_o is gated by reset so it stays low while reset is held
  assign ready_o    = rst_n_i & (state_q == ST_IDLE);
  assign valid_o    = (state_q == ST_DONE);
  assign exp_o      = exp_q;
  assign man_o      = man_q;
  assign man_sign_o = man_q[MAN_MAX_W-1];
  assign zero_o     = zero_q;

endmodule : iob_ptfloat_normalize
`default_nettype wire

// File: tb/tb_iob_ptfloat_normalize.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_iob_ptfloat_normalize                                |
// | Brief    : Self-checking bench for iob_ptfloat_normalize with an   |
// |            integer-arithmetic reference model.                     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_iob_ptfloat_normalize;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [16:0] exp_i;
  logic [29:0] man_i;
  logic        valid_o;
  logic        ready_i;
  logic [16:0] exp_o;
  logic [27:0] man_o;
  logic        man_sign_o;
  logic        zero_o;

  int errors = 0;
  int checks = 0;

  iob_ptfloat_normalize #(.DATA_W(32), .EW_W(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .exp_i      (exp_i),
    .man_i      (man_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .exp_o      (exp_o),
    .man_o      (man_o),
    .man_sign_o (man_sign_o),
    .zero_o     (zero_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: treat the mantissa as a signed integer and apply the range
  // rules directly; left shifts are doublings while it fits 27 signed bits.
  task automatic model(input logic [29:0] man, input logic [16:0] ex,
                       output logic [27:0] mo, output logic [16:0] eo,
                       output logic z, output int lat);
    longint v;
    longint lim26, lim27, lim28;
    int     e;
    int     n;
    bit     done;
    lim26 = longint'(1) << 26;
    lim27 = longint'(1) << 27;
    lim28 = longint'(1) << 28;
    v = longint'($signed(man));
    e = int'($signed(ex));
    n = 0;
    z = 1'b0;
    done = 1'b0;
    while (!done) begin
      if (v == 0) begin
        z = 1'b1; e = 0; done = 1'b1;
      end else if (v >= lim28 || v < -lim28) begin
        v = v >>> 2; e = e + 2; done = 1'b1;
      end else if (v >= lim27 || v < -lim27) begin
        v = v >>> 1; e = e + 1; done = 1'b1;
      end else if (v >= lim26 || v < -lim26) begin
        done = 1'b1;
      end else if (e == -65536) begin
        done = 1'b1;
      end else begin
        v = v * 2; e = e - 1; n++;
      end
    end
    mo  = 28'(v);
    eo  = 17'(e);
    lat = 2 + n;
  endtask

  task automatic send(input logic [29:0] man, input logic [16:0] ex);
    int k;
    k = 0;
    while (ready_o !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send ready_o", ready_o, 1);
    valid_i = 1'b1;
    man_i   = man;
    exp_i   = ex;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    man_i   = $urandom;
    exp_i   = 17'($urandom);
  endtask

  task automatic expect_result(input logic [29:0] man, input logic [16:0] ex,
                               input int hold, input string tag);
    logic [27:0] mo;
    logic [16:0] eo;
    logic        z;
    int          lat;
    int          k;
    bit          got;
    model(man, ex, mo, eo, z, lat);
    k = 0;
    got = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (valid_o === 1'b1) got = 1'b1;
      else check({tag, " busy ready_o"}, ready_o, 0);
    end
    check({tag, " valid_o"}, valid_o, 1);
    if (!got) return;
    check({tag, " latency"}, k, lat);
    check({tag, " man_o"}, man_o, mo);
    check({tag, " exp_o"}, exp_o, eo);
    check({tag, " zero_o"}, zero_o, z);
    check({tag, " man_sign_o"}, man_sign_o, mo[27]);
    check({tag, " ready_o in done"}, ready_o, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid_o"}, valid_o, 1);
      check({tag, " hold ready_o"}, ready_o, 0);
      check({tag, " hold man_o"}, man_o, mo);
      check({tag, " hold exp_o"}, exp_o, eo);
      check({tag, " hold zero_o"}, zero_o, z);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    @(negedge clk);
    check({tag, " post valid_o"}, valid_o, 0);
    check({tag, " post ready_o"}, ready_o, 1);
  endtask

  task automatic op(input logic [29:0] man, input logic [16:0] ex,
                    input int hold, input string tag);
    send(man, ex);
    expect_result(man, ex, hold, tag);
  endtask

  initial begin
    logic signed [29:0] t;
    logic [29:0]        rm;
    logic [16:0]        re;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    man_i   = '0;
    exp_i   = '0;
    repeat (3) @(negedge clk);
    check("reset ready_o", ready_o, 0);
    check("reset valid_o", valid_o, 0);
    check("reset man_o", man_o, 0);
    check("reset exp_o", exp_o, 0);
    check("reset zero_o", zero_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk);
    check("release ready_o", ready_o, 1);

    op(30'h0400_0000, 17'd5, 0, "already_norm");
    op(30'h0000_0001, 17'd0, 0, "shift26");
    op(30'h1000_0000, 17'd3, 1, "right2");
    op(30'h0800_0000, 17'd9, 0, "right1");
    op(30'h0000_0000, 17'd7, 0, "zero");
    op(30'h3FFF_FFFF, 17'd0, 10, "minus_one_bp");
    op(30'h0000_0001, 17'h10003, 0, "floor_after3");
    op(30'h0000_0001, 17'h10000, 0, "floor_entry");
    op(30'h2000_0000, 17'd4, 0, "neg_right2");

    // Reset part-way through a long normalization
    send(30'h0000_0001, 17'd0);
    repeat (5) @(negedge clk);
    check("midnorm valid_o", valid_o, 0);
    rst_n_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst valid_o", valid_o, 0);
    check("rst ready_o", ready_o, 0);
    check("rst man_o", man_o, 0);
    check("rst exp_o", exp_o, 0);
    check("rst zero_o", zero_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk);
    check("rst release ready_o", ready_o, 1);
    check("rst release valid_o", valid_o, 0);

    op(30'h0000_0003, 17'd100, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      t  = 30'($urandom);
      rm = 30'(t >>> $urandom_range(0, 29));
      if ($urandom_range(0, 3) == 0) re = 17'(-65536 + int'($urandom_range(0, 30)));
      else re = 17'(int'($urandom_range(0, 120000)) - 60000);
      op(rm, re, int'($urandom_range(0, 3)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_iob_ptfloat_normalize
`default_nettype wire
